// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit framing stage.
// Holds the FSM state encoding and the fixed line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LVL = 1'b1;
    localparam logic START_LVL   = 1'b0;
    localparam logic STOP_LVL    = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Frame data latch, shared bit/stop counter and LSB-first bit selection.
// The controlling FSM decides when to load, clear or advance.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  cnt_clr,
    input  logic                  cnt_inc,
    output logic [DATA_WIDTH-1:0] data_lat,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic                  cnt_last,
    output logic                  first_bit,
    output logic                  next_bit
);

    logic [CNT_WIDTH-1:0] next_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_lat <= '0;
        end else if (load) begin
            data_lat <= p_data;
        end
    end

    // Saturates at the last data bit so it can never wrap mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc && !cnt_last) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        cnt_last  = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
        next_idx  = cnt + CNT_WIDTH'(1);
        first_bit = data_lat[0];
        next_bit  = cnt_last ? STOP_LVL : data_lat[next_idx];
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framing controller: start, LSB-first data, optional parity, stop bits.
// One clock is one bit period; tx_out and busy are registered.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_bit,
    output logic [DATA_WIDTH-1:0] data_lat,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

    tx_state_t            state_q;
    tx_state_t            state_d;
    logic                 par_en_q;
    logic                 par_en_d;
    logic                 tx_out_d;
    logic                 busy_d;
    logic                 load;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_last;
    logic                 first_bit;
    logic                 next_bit;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .p_data    (p_data),
        .cnt_clr   (cnt_clr),
        .cnt_inc   (cnt_inc),
        .data_lat  (data_lat),
        .cnt       (cnt),
        .cnt_last  (cnt_last),
        .first_bit (first_bit),
        .next_bit  (next_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            par_en_q <= 1'b0;
            tx_out   <= TX_IDLE_LVL;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            par_en_q <= par_en_d;
            tx_out   <= tx_out_d;
            busy     <= busy_d;
        end
    end

    // Each branch sets the line level for the slot being entered, so the
    // start bit appears on the very edge that accepts the byte.
    always_comb begin
        state_d  = state_q;
        par_en_d = par_en_q;
        tx_out_d = tx_out;
        busy_d   = busy;
        load     = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_out_d = TX_IDLE_LVL;
                busy_d   = 1'b0;
                if (data_valid) begin
                    load     = 1'b1;
                    par_en_d = par_en;
                    cnt_clr  = 1'b1;
                    tx_out_d = START_LVL;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                cnt_clr  = 1'b1;
                tx_out_d = first_bit;
                state_d  = DATA;
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_clr = 1'b1;
                    if (par_en_q) begin
                        tx_out_d = par_bit;
                        state_d  = PARITY;
                    end else begin
                        tx_out_d = STOP_LVL;
                        state_d  = STOP;
                    end
                end else begin
                    cnt_inc  = 1'b1;
                    tx_out_d = next_bit;
                end
            end
            PARITY: begin
                cnt_clr  = 1'b1;
                tx_out_d = STOP_LVL;
                state_d  = STOP;
            end
            STOP: begin
                tx_out_d = STOP_LVL;
                if (cnt == CNT_WIDTH'(STOP_BITS - 1)) begin
                    cnt_clr = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                tx_out_d = TX_IDLE_LVL;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: one- and two-stop-bit instances share stimulus,
// each tracked by a frame-level reference model and a behavioural parity generator.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       dataValid;
    logic       parEn;
    logic       parityType;
    logic [7:0] pData;
    logic [7:0] lat1, lat2;
    logic       tx1, tx2, busy1, busy2;
    logic       par1, par2;
    logic       checkEn = 1'b0;
    int         checks = 0;
    int         failures = 0;

    logic        m1Tx = 1'b1, m2Tx = 1'b1;
    logic        m1Busy = 1'b0, m2Busy = 1'b0;
    logic [7:0]  m1Lat = 8'h00, m2Lat = 8'h00;
    logic [15:0] m1Frame = '1, m2Frame = '1;
    int          m1Len = 0, m2Len = 0;
    int          m1Idx = 0, m2Idx = 0;

    always #5 clk = ~clk;

    // Parity generator as it sits upstream: even when parityType=0, odd when 1.
    assign par1 = ^lat1 ^ parityType;
    assign par2 = ^lat2 ^ parityType;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rstN), .p_data(pData), .data_valid(dataValid),
        .par_en(parEn), .par_bit(par1), .data_lat(lat1), .tx_out(tx1), .busy(busy1)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rstN), .p_data(pData), .data_valid(dataValid),
        .par_en(parEn), .par_bit(par2), .data_lat(lat2), .tx_out(tx2), .busy(busy2)
    );

    // Whole frame as a bit string, bit 0 first on the line; trailing ones are stop bits.
    function automatic logic [15:0] frameBits(input logic [7:0] d, input logic pe, input logic odd);
        logic [15:0] f;
        int ones;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        ones   = $countones(d);
        if (pe) f[9] = ((ones % 2) == 1) ? ~odd : odd;
        return f;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m1Tx <= 1'b1; m1Busy <= 1'b0; m1Lat <= 8'h00; m1Idx <= 0; m1Len <= 0;
        end else if (m1Idx < m1Len) begin
            m1Tx  <= m1Frame[m1Idx];
            m1Idx <= m1Idx + 1;
        end else if (m1Busy) begin
            m1Busy <= 1'b0; m1Tx <= 1'b1;
        end else if (dataValid) begin
            m1Frame <= frameBits(pData, parEn, parityType);
            m1Len   <= 1 + 8 + (parEn ? 1 : 0) + 1;
            m1Idx   <= 1;
            m1Tx    <= 1'b0; m1Busy <= 1'b1; m1Lat <= pData;
        end
    end

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m2Tx <= 1'b1; m2Busy <= 1'b0; m2Lat <= 8'h00; m2Idx <= 0; m2Len <= 0;
        end else if (m2Idx < m2Len) begin
            m2Tx  <= m2Frame[m2Idx];
            m2Idx <= m2Idx + 1;
        end else if (m2Busy) begin
            m2Busy <= 1'b0; m2Tx <= 1'b1;
        end else if (dataValid) begin
            m2Frame <= frameBits(pData, parEn, parityType);
            m2Len   <= 1 + 8 + (parEn ? 1 : 0) + 2;
            m2Idx   <= 1;
            m2Tx    <= 1'b0; m2Busy <= 1'b1; m2Lat <= pData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("tx1", 32'(tx1), 32'(m1Tx));
            checkOutput("busy1", 32'(busy1), 32'(m1Busy));
            checkOutput("lat1", 32'(lat1), 32'(m1Lat));
            checkOutput("tx2", 32'(tx2), 32'(m2Tx));
            checkOutput("busy2", 32'(busy2), 32'(m2Busy));
            checkOutput("lat2", 32'(lat2), 32'(m2Lat));
        end
    end

    task automatic applyStimulus(input logic valid, input logic [7:0] d, input logic pe);
        @(negedge clk);
        dataValid = valid;
        pData     = d;
        parEn     = pe;
    endtask

    // One-cycle request, then scrambles P_DATA/PAR_EN while counting busy cycles
    // and capturing the leading line bits of the one-stop instance.
    task automatic runFrame(input logic [7:0] d, input logic pe, input int exp1, input int exp2,
                            input logic [31:0] expSeq);
        int n1 = 0;
        int n2 = 0;
        logic [31:0] seq = '0;
        applyStimulus(1'b1, d, pe);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dataValid = 1'b0;
            pData     = 8'($urandom);
            parEn     = ~pe;
            if (busy1) n1++;
            if (busy2) n2++;
            if (i < exp1) seq = {seq[30:0], tx1};
        end
        checkOutput("busyLen1", 32'(n1), 32'(exp1));
        checkOutput("busyLen2", 32'(n2), 32'(exp2));
        checkOutput("lineSeq1", seq, expSeq);
    endtask

    initial begin
        int lowRun;
        int gap;
        int frames;
        logic prevBusy;

        rstN = 1'b0; dataValid = 1'b0; pData = 8'h00; parEn = 1'b0; parityType = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstTx1", 32'(tx1), 32'd1);
        checkOutput("rstBusy1", 32'(busy1), 32'd0);
        checkOutput("rstLat1", 32'(lat1), 32'd0);
        checkOutput("rstTx2", 32'(tx2), 32'd1);
        checkOutput("rstBusy2", 32'(busy2), 32'd0);
        rstN = 1'b1;
        checkEn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] 0xA5 even parity, then odd parity, then 0x3C without parity");
        parityType = 1'b0;
        runFrame(8'hA5, 1'b1, 11, 12, 32'b01010010101);
        parityType = 1'b1;
        runFrame(8'hA5, 1'b1, 11, 12, 32'b01010010111);
        parityType = 1'b0;
        runFrame(8'h3C, 1'b0, 10, 11, 32'b0001111001);

        $display("[TB] request during an active frame is dropped");
        applyStimulus(1'b1, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        dataValid = 1'b1; pData = 8'hFF;
        @(negedge clk);
        dataValid = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("ignoreLat1", 32'(lat1), 32'h00);
        checkOutput("ignoreLat2", 32'(lat2), 32'h00);

        $display("[TB] held request gives back-to-back frames");
        applyStimulus(1'b1, 8'h11, 1'b0);
        lowRun = 0; gap = -1; frames = 0; prevBusy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) pData = 8'h22;
            if (i == 11) dataValid = 1'b0;
            if (busy1 && !prevBusy) begin
                if (frames > 0 && gap < 0) gap = lowRun;
                frames++;
                lowRun = 0;
            end else if (!busy1 && frames > 0) begin
                lowRun++;
            end
            prevBusy = busy1;
        end
        checkOutput("b2bFrames", 32'(frames), 32'd2);
        checkOutput("b2bGap", 32'(gap), 32'd1);
        checkOutput("b2bLat", 32'(lat1), 32'h22);

        $display("[TB] asynchronous reset during data bit 3");
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("preRstBusy1", 32'(busy1), 32'd1);
        checkOutput("preRstTx1", 32'(tx1), 32'd0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("asyncTx1", 32'(tx1), 32'd1);
        checkOutput("asyncBusy1", 32'(busy1), 32'd0);
        checkOutput("asyncLat1", 32'(lat1), 32'd0);
        checkOutput("asyncTx2", 32'(tx2), 32'd1);
        checkOutput("asyncBusy2", 32'(busy2), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            dataValid = ($urandom_range(0, 3) == 0);
            pData     = 8'($urandom);
            parEn     = 1'($urandom_range(0, 1));
            if (!m1Busy && !m2Busy) parityType = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                #1 rstN = 1'b0;
                #1 rstN = 1'b1;
            end
        end
        dataValid = 1'b0;
        repeat (20) @(negedge clk);
        checkEn = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
